// File: rtl/mer_meter_pam.sv
// MER measurement engine: learns the reference level over a calibration window,
// then slices symbols and averages error, error^2 and ideal-symbol power per window.
module mer_meter_pam #(
  parameter int IN_W   = 18,
  parameter int LOG2_N = 10,
  parameter int OUT_W  = 36
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sym_clk_en,
  input  logic signed [IN_W-1:0]  dec_var,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode_4pam,
  input  logic                    cont,
  output logic                    busy,
  output logic signed [IN_W-1:0]  ref_lvl,
  output logic signed [IN_W:0]    err_avg,
  output logic [OUT_W-1:0]        err_sq_avg,
  output logic [OUT_W-1:0]        sig_pwr,
  output logic                    result_valid,
  output logic [1:0]              dbg_state
);

  localparam int EW  = IN_W + 1;
  localparam int SQW = 2 * EW;
  localparam int MAW = IN_W + LOG2_N;
  localparam int EAW = EW + LOG2_N;
  localparam int SAW = SQW + LOG2_N;
  localparam logic [IN_W-1:0] MIN_V = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MAX_V = {1'b0, {(IN_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAL  = 2'd1,
    S_MEAS = 2'd2
  } state_t;

  state_t              state_q;
  logic                mode_q, cont_q, stop_q;
  logic [LOG2_N-1:0]   cnt_q;

  logic                s1_vld_q, s1_last_q, s1_meas_q;
  logic [IN_W-1:0]     s1_abs_q;
  logic signed [EW-1:0] s1_err_q, s1_ideal_q;

  logic [MAW-1:0]      mag_acc_q;
  logic signed [EAW-1:0] err_acc_q;
  logic [SAW-1:0]      sq_acc_q, pwr_acc_q;

  logic [IN_W-1:0]     ref_q;
  logic signed [EW-1:0] err_avg_q;
  logic [OUT_W-1:0]    err_sq_avg_q, sig_pwr_q;
  logic                result_valid_q;

  logic                sym_ok, win_end;
  logic [MAW-1:0]      mag_sum;
  logic [IN_W-1:0]     ref_new, ref_eff, abs_d;
  logic signed [EW-1:0] r_x, half_x, three_x, neg_r_x, x_x, ideal_d, err_d;
  logic signed [SQW-1:0] e_w, i_w, err_sq, pwr_sq;
  logic signed [EAW-1:0] err_sum;
  logic [SAW-1:0]      sq_sum, pwr_sum;
  logic [SQW-1:0]      sq_mean, pwr_mean;
  logic [OUT_W-1:0]    sq_sat, pwr_sat;

  assign sym_ok  = sym_clk_en && (state_q != S_IDLE);
  assign win_end = sym_ok && (cnt_q == {LOG2_N{1'b1}});

  // A window-end symbol still in stage 2 updates ref this cycle; a symbol arriving
  // now belongs to the next window and must already slice against that new level.
  always_comb begin
    mag_sum = mag_acc_q + {{LOG2_N{1'b0}}, s1_abs_q};
    ref_new = mag_sum[MAW-1:LOG2_N];
    ref_eff = (s1_vld_q && s1_last_q) ? ref_new : ref_q;
    r_x     = {ref_eff[IN_W-1], ref_eff};
    half_x  = r_x >>> 1;
    three_x = r_x + half_x;
    neg_r_x = -r_x;
    x_x     = {dec_var[IN_W-1], dec_var};
    ideal_d = '0;
    if (mode_q) begin
      if (x_x >= r_x)        ideal_d = three_x;
      else if (!x_x[EW-1])   ideal_d = half_x;
      else if (x_x >= neg_r_x) ideal_d = -half_x;
      else                   ideal_d = -three_x;
    end else begin
      ideal_d = x_x[EW-1] ? neg_r_x : r_x;
    end
    err_d = x_x - ideal_d;
    if (dec_var == MIN_V)      abs_d = MAX_V;
    else if (dec_var[IN_W-1])  abs_d = -dec_var;
    else                       abs_d = dec_var;
  end

  always_comb begin
    e_w      = {{EW{s1_err_q[EW-1]}}, s1_err_q};
    i_w      = {{EW{s1_ideal_q[EW-1]}}, s1_ideal_q};
    err_sq   = e_w * e_w;
    pwr_sq   = i_w * i_w;
    err_sum  = err_acc_q + {{LOG2_N{s1_err_q[EW-1]}}, s1_err_q};
    sq_sum   = sq_acc_q + {{LOG2_N{1'b0}}, err_sq};
    pwr_sum  = pwr_acc_q + {{LOG2_N{1'b0}}, pwr_sq};
    sq_mean  = sq_sum[SAW-1:LOG2_N];
    pwr_mean = pwr_sum[SAW-1:LOG2_N];
    sq_sat   = (|sq_mean[SQW-1:OUT_W])  ? {OUT_W{1'b1}} : sq_mean[OUT_W-1:0];
    pwr_sat  = (|pwr_mean[SQW-1:OUT_W]) ? {OUT_W{1'b1}} : pwr_mean[OUT_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CAL;
            mode_q  <= mode_4pam;
            cont_q  <= cont;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_CAL: begin
          if (stop) stop_q <= 1'b1;
          if (sym_ok) cnt_q <= cnt_q + LOG2_N'(1);
          if (win_end) state_q <= S_MEAS;
        end
        S_MEAS: begin
          if (stop) stop_q <= 1'b1;
          if (sym_ok) cnt_q <= cnt_q + LOG2_N'(1);
          if (win_end && !(cont_q && !stop_q && !stop)) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      s1_vld_q       <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_meas_q      <= 1'b0;
      s1_abs_q       <= '0;
      s1_err_q       <= '0;
      s1_ideal_q     <= '0;
      mag_acc_q      <= '0;
      err_acc_q      <= '0;
      sq_acc_q       <= '0;
      pwr_acc_q      <= '0;
      ref_q          <= '0;
      err_avg_q      <= '0;
      err_sq_avg_q   <= '0;
      sig_pwr_q      <= '0;
      result_valid_q <= 1'b0;
    end else begin
      s1_vld_q       <= sym_ok;
      result_valid_q <= 1'b0;
      if (sym_ok) begin
        s1_abs_q   <= abs_d;
        s1_err_q   <= err_d;
        s1_ideal_q <= ideal_d;
        s1_last_q  <= win_end;
        s1_meas_q  <= (state_q == S_MEAS);
      end
      if (s1_vld_q) begin
        if (s1_last_q) begin
          mag_acc_q <= '0;
          err_acc_q <= '0;
          sq_acc_q  <= '0;
          pwr_acc_q <= '0;
          ref_q     <= ref_new;
          if (s1_meas_q) begin
            err_avg_q      <= err_sum[EAW-1:LOG2_N];
            err_sq_avg_q   <= sq_sat;
            sig_pwr_q      <= pwr_sat;
            result_valid_q <= 1'b1;
          end
        end else begin
          mag_acc_q <= mag_sum;
          if (s1_meas_q) begin
            err_acc_q <= err_sum;
            sq_acc_q  <= sq_sum;
            pwr_acc_q <= pwr_sum;
          end
        end
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign ref_lvl      = ref_q;
  assign err_avg      = err_avg_q;
  assign err_sq_avg   = err_sq_avg_q;
  assign sig_pwr      = sig_pwr_q;
  assign result_valid = result_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mer_meter_pam.sv
// Bench for mer_meter_pam with 16-symbol windows: stimulus pushes expected window
// results, a negedge monitor pops them on every result_valid pulse.
module tb_mer_meter_pam;

  localparam int IN_W   = 18;
  localparam int LOG2_N = 4;
  localparam int OUT_W  = 36;
  localparam int N      = 1 << LOG2_N;

  logic                   sys_clk = 1'b0;
  logic                   reset, sym_clk_en, start, stop, mode_4pam, cont;
  logic signed [IN_W-1:0] dec_var;
  logic                   busy, result_valid;
  logic signed [IN_W-1:0] ref_lvl;
  logic signed [IN_W:0]   err_avg;
  logic [OUT_W-1:0]       err_sq_avg, sig_pwr;
  logic [1:0]             dbg_state;

  mer_meter_pam #(.IN_W(IN_W), .LOG2_N(LOG2_N), .OUT_W(OUT_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .dec_var(dec_var),
    .start(start), .stop(stop), .mode_4pam(mode_4pam), .cont(cont),
    .busy(busy), .ref_lvl(ref_lvl), .err_avg(err_avg), .err_sq_avg(err_sq_avg),
    .sig_pwr(sig_pwr), .result_valid(result_valid), .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [IN_W-1:0]  r;
    logic [IN_W:0]    ea;
    logic [OUT_W-1:0] sq;
    logic [OUT_W-1:0] pw;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int n_pushed = 0;
  int n_results = 0;
  longint bench_ref = 0;
  logic signed [IN_W-1:0] win_x [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_exp(input longint r, input longint ea, input longint sq, input longint pw);
    exp_t e;
    e.r  = IN_W'(r);
    e.ea = (IN_W+1)'(ea);
    e.sq = OUT_W'(sq);
    e.pw = OUT_W'(pw);
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Reference model of one window, sliced against the level learnt from the previous window.
  task automatic model_window(input bit m4, input bit meas);
    longint r, h, t, x, id, er, es, ss, ps, ms, sqm, pwm;
    r = bench_ref; h = r >>> 1; t = r + h;
    es = 0; ss = 0; ps = 0; ms = 0;
    for (int i = 0; i < N; i++) begin
      x = longint'(win_x[i]);
      if (m4) begin
        if (x >= r)       id = t;
        else if (x >= 0)  id = h;
        else if (x >= -r) id = -h;
        else              id = -t;
      end else begin
        id = (x >= 0) ? r : -r;
      end
      er = x - id;
      es += er; ss += er * er; ps += id * id;
      if (x == -(longint'(1) << (IN_W-1))) ms += (longint'(1) << (IN_W-1)) - 1;
      else ms += (x < 0) ? -x : x;
    end
    if (meas) begin
      sqm = ss >>> LOG2_N;
      pwm = ps >>> LOG2_N;
      if (sqm > (longint'(1) << OUT_W) - 1) sqm = (longint'(1) << OUT_W) - 1;
      if (pwm > (longint'(1) << OUT_W) - 1) pwm = (longint'(1) << OUT_W) - 1;
      push_exp(ms >>> LOG2_N, es >>> LOG2_N, sqm, pwm);
    end
    bench_ref = ms >>> LOG2_N;
  endtask

  task automatic sym(input logic signed [IN_W-1:0] x, input int gap);
    sym_clk_en = 1'b1;
    dec_var    = x;
    tick();
    sym_clk_en = 1'b0;
    dec_var    = '0;
    repeat (gap - 1) tick();
  endtask

  task automatic pulse_start(input bit m4, input bit c);
    mode_4pam = m4;
    cont      = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // inj_kind: 1 = stop pulse, 2 = start pulse with mode/cont flipped (while busy)
  task automatic run_window(input bit push_model, input bit m4, input bit rnd_gap,
                            input int inj_at, input int inj_kind);
    int gap;
    model_window(m4, push_model);
    for (int i = 0; i < N; i++) begin
      if (i == inj_at && inj_kind == 1) begin
        stop = 1'b1; tick(); stop = 1'b0;
      end
      if (i == inj_at && inj_kind == 2) begin
        mode_4pam = ~m4; cont = 1'b1; start = 1'b1; tick(); start = 1'b0;
      end
      gap = 1;
      if (rnd_gap) begin
        case ($urandom_range(0, 2))
          0: gap = 2;
          1: gap = 3;
          default: gap = 7;
        endcase
      end
      sym(win_x[i], gap);
    end
  endtask

  task automatic fill_pattern(input logic signed [IN_W-1:0] a, input logic signed [IN_W-1:0] b,
                              input logic signed [IN_W-1:0] c, input logic signed [IN_W-1:0] d);
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: win_x[i] = a;
        1: win_x[i] = b;
        2: win_x[i] = c;
        default: win_x[i] = d;
      endcase
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) win_x[i] = $signed(IN_W'($urandom_range(0, (1 << IN_W) - 1)));
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_ref"}, 64'($unsigned(ref_lvl)), 64'd0);
    check({tag, "_err_avg"}, 64'($unsigned(err_avg)), 64'd0);
    check({tag, "_err_sq"}, 64'(err_sq_avg), 64'd0);
    check({tag, "_sig_pwr"}, 64'(sig_pwr), 64'd0);
    check({tag, "_rv"}, 64'(result_valid), 64'd0);
  endtask

  always @(negedge sys_clk) begin
    if (reset && result_valid) begin
      n_results++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ref_lvl", 64'($unsigned(ref_lvl)), 64'(mon_e.r));
        check("err_avg", 64'($unsigned(err_avg)), 64'(mon_e.ea));
        check("err_sq_avg", 64'(err_sq_avg), 64'(mon_e.sq));
        check("sig_pwr", 64'(sig_pwr), 64'(mon_e.pw));
      end
    end
  end

  initial begin
    reset = 1'b0; sym_clk_en = 1'b0; dec_var = '0;
    start = 1'b0; stop = 1'b0; mode_4pam = 1'b0; cont = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // T1: 4-PAM noiseless, single shot
    pulse_start(1'b1, 1'b0);
    fill_pattern(18'sh01000, 18'sh03000, -18'sh01000, -18'sh03000);
    run_window(1'b0, 1'b1, 1'b0, -1, 0);
    push_exp(64'h2000, 0, 0, 64'h5000000);
    run_window(1'b0, 1'b1, 1'b0, -1, 0);
    drain("t1_drain");
    repeat (3) tick();
    check("t1_busy_after", 64'(busy), 64'd0);

    // T2: constant +0x100 offset
    pulse_start(1'b1, 1'b0);
    fill_pattern(18'sh01100, 18'sh03100, -18'sh00F00, -18'sh02F00);
    run_window(1'b0, 1'b1, 1'b0, -1, 0);
    push_exp(64'h2000, 64'h100, 64'h10000, 64'h5000000);
    run_window(1'b0, 1'b1, 1'b0, -1, 0);
    drain("t2_drain");

    // T3: 2-PAM with alternating +-0x40 noise
    pulse_start(1'b0, 1'b0);
    fill_pattern(18'sh02040, 18'sh01FC0, -18'sh01FC0, -18'sh02040);
    run_window(1'b0, 1'b0, 1'b0, -1, 0);
    push_exp(64'h2000, 0, 64'h1000, 64'h4000000);
    run_window(1'b0, 1'b0, 1'b0, -1, 0);
    drain("t3_drain");

    // T4: continuous with sparse strobes, stop in the second measured window
    pulse_start(1'b1, 1'b1);
    fill_random();
    run_window(1'b0, 1'b1, 1'b1, -1, 0);
    fill_random();
    run_window(1'b1, 1'b1, 1'b1, -1, 0);
    fill_random();
    run_window(1'b1, 1'b1, 1'b1, 8, 1);
    drain("t4_drain");
    repeat (3) tick();
    check("t4_busy_after_stop", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) sym(18'sh01234, 2);
    repeat (5) tick();

    // T5a: start while busy is ignored (counter, mode and cont kept)
    pulse_start(1'b1, 1'b0);
    fill_random();
    run_window(1'b0, 1'b1, 1'b0, 5, 2);
    fill_random();
    run_window(1'b1, 1'b1, 1'b0, -1, 0);
    drain("t5_drain");
    repeat (3) tick();
    check("t5_busy_after", 64'(busy), 64'd0);

    // T5b: reset in the middle of a measured window
    pulse_start(1'b1, 1'b1);
    fill_random();
    run_window(1'b0, 1'b1, 1'b0, -1, 0);
    for (int i = 0; i < N / 2; i++) sym(18'sh02000, 1);
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    reset = 1'b1;
    bench_ref = 0;
    tick();

    // T6: most negative input everywhere
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < N; i++) win_x[i] = -18'sh20000;
    run_window(1'b0, 1'b1, 1'b0, -1, 0);
    run_window(1'b1, 1'b1, 1'b0, -1, 0);
    drain("t6_drain");

    repeat (5) tick();
    check("result_count", 64'(n_results), 64'(n_pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
